// File: rtl/wb_port_arbiter.sv
// Shares one scoreboard writeback port among NR_REQ functional units. Each unit
// gets a one-entry hold buffer, and the buffers drain onto the port in round-robin order.
package wb_port_arbiter_pkg;
  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;
endpackage

module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ = 3,
  parameter int unsigned XLEN   = 64,
  parameter int unsigned TID_W  = 3,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned PTR_W = $clog2(NR_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic [NR_REQ-1:0]         req_valid_i,
  output logic [NR_REQ-1:0]         req_ready_o,
  input  logic [NR_REQ*XLEN-1:0]    req_result_i,
  input  logic [NR_REQ*TID_W-1:0]   req_trans_id_i,
  input  exception_t [NR_REQ-1:0]   req_exception_i,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [XLEN-1:0]           wb_result_o,
  output logic [TID_W-1:0]          wb_trans_id_o,
  output exception_t                wb_exception_o,
  output logic [NR_REQ-1:0]         wb_grant_o,
  output logic [CNT_W-1:0]          conflict_cnt_o,
  output logic [NR_REQ-1:0]         dbg_state_o,
  output logic [PTR_W-1:0]          dbg_rr_ptr_o
);

  // Handshake: a transfer happens on every edge where valid and ready are both
  // high; a valid payload holds stable until taken, and ready never depends on valid.

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  buf_state_e        state_q [NR_REQ];
  buf_state_e        state_d [NR_REQ];
  logic [XLEN-1:0]   result_q [NR_REQ];
  logic [TID_W-1:0]  tid_q [NR_REQ];
  exception_t        exc_q [NR_REQ];

  logic [NR_REQ-1:0] full;
  logic [NR_REQ-1:0] accept;
  logic [NR_REQ-1:0] pop;
  logic              any_full;
  logic              conflict;
  logic              handshake;
  logic [PTR_W-1:0]  rr_ptr_q;
  logic [PTR_W-1:0]  grant_idx;
  logic              lock_q;
  logic [PTR_W-1:0]  lock_idx_q;
  logic [CNT_W-1:0]  cnt_q;

  always_comb begin
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      full[i] = (state_q[i] == BUF_FULL);
    end
  end

  assign any_full = |full;
  // x & (x-1) is non-zero exactly when at least two bits are set
  assign conflict = |(full & (full - NR_REQ'(1)));

  // Search upward from rr_ptr; a stalled presentation stays locked so a late fill cannot preempt it.
  always_comb begin
    logic             found;
    int unsigned      j;
    logic [PTR_W-1:0] jj;
    found     = 1'b0;
    j         = 0;
    jj        = '0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NR_REQ; k++) begin
      j = 32'(rr_ptr_q) + k;
      if (j >= NR_REQ) j = j - NR_REQ;
      jj = PTR_W'(j);
      if (!found && full[jj]) begin
        grant_idx = jj;
        found     = 1'b1;
      end
    end
    if (lock_q) grant_idx = lock_idx_q;
  end

  always_comb begin
    wb_grant_o = '0;
    if (any_full) wb_grant_o[grant_idx] = 1'b1;
  end

  assign handshake   = any_full & wb_ready_i & ~flush_i;
  assign pop         = wb_grant_o & {NR_REQ{handshake}};
  assign req_ready_o = {NR_REQ{~flush_i}} & (~full | (wb_grant_o & {NR_REQ{wb_ready_i}}));
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      state_d[i] = state_q[i];
      if (flush_i)        state_d[i] = BUF_EMPTY;
      else if (accept[i]) state_d[i] = BUF_FULL;
      else if (pop[i])    state_d[i] = BUF_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NR_REQ; i++) state_q[i] <= BUF_EMPTY;
    end else begin
      for (int unsigned i = 0; i < NR_REQ; i++) state_q[i] <= state_d[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NR_REQ; i++) begin
        result_q[i] <= '0;
        tid_q[i]    <= '0;
        exc_q[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NR_REQ; i++) begin
        if (accept[i]) begin
          result_q[i] <= req_result_i[i*XLEN +: XLEN];
          tid_q[i]    <= req_trans_id_i[i*TID_W +: TID_W];
          exc_q[i]    <= req_exception_i[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      if (handshake) begin
        rr_ptr_q <= (grant_idx == PTR_W'(NR_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
      lock_q     <= any_full & ~wb_ready_i & ~flush_i;
      lock_idx_q <= grant_idx;
      if (conflict && !flush_i && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign wb_valid_o     = any_full;
  assign wb_result_o    = any_full ? result_q[grant_idx] : '0;
  assign wb_trans_id_o  = any_full ? tid_q[grant_idx] : '0;
  assign wb_exception_o = any_full ? exc_q[grant_idx] : '0;
  assign conflict_cnt_o = cnt_q;
  assign dbg_state_o    = full;
  assign dbg_rr_ptr_o   = rr_ptr_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: single transfer, round-robin, backpressure,
// pass-through refill, flush and conflict-counter saturation.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int NR   = 3;
  localparam int XLEN = 64;
  localparam int TID  = 3;
  localparam int CW   = 4;
  localparam int PW   = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 flush_i;
  logic [NR-1:0]        req_valid_i;
  logic [NR-1:0]        req_ready_o;
  logic [NR*XLEN-1:0]   req_result_i;
  logic [NR*TID-1:0]    req_trans_id_i;
  exception_t [NR-1:0]  req_exception_i;
  logic                 wb_valid_o;
  logic                 wb_ready_i;
  logic [XLEN-1:0]      wb_result_o;
  logic [TID-1:0]       wb_trans_id_o;
  exception_t           wb_exception_o;
  logic [NR-1:0]        wb_grant_o;
  logic [CW-1:0]        conflict_cnt_o;
  logic [NR-1:0]        dbg_state_o;
  logic [PW-1:0]        dbg_rr_ptr_o;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.NR_REQ(NR), .XLEN(XLEN), .TID_W(TID), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_result_i(req_result_i), .req_trans_id_i(req_trans_id_i),
    .req_exception_i(req_exception_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_result_o(wb_result_o), .wb_trans_id_o(wb_trans_id_o),
    .wb_exception_o(wb_exception_o), .wb_grant_o(wb_grant_o),
    .conflict_cnt_o(conflict_cnt_o),
    .dbg_state_o(dbg_state_o), .dbg_rr_ptr_o(dbg_rr_ptr_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    flush_i         = 1'b0;
    req_valid_i     = '0;
    req_result_i    = '0;
    req_trans_id_i  = '0;
    req_exception_i = '0;
    wb_ready_i      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    settle();
  endtask

  task automatic drive_req(input int i, input logic [XLEN-1:0] res, input logic [TID-1:0] tid);
    req_valid_i[i]                 = 1'b1;
    req_result_i[i*XLEN +: XLEN]   = res;
    req_trans_id_i[i*TID +: TID]   = tid;
  endtask

  initial begin
    exception_t exc;
    clear_inputs();
    rst_ni = 1'b0;

    // reset state and single requester
    do_reset();
    check("rst_valid", 128'(wb_valid_o), 128'(0));
    check("rst_grant", 128'(wb_grant_o), 128'(0));
    check("rst_result", 128'(wb_result_o), 128'(0));
    check("rst_tid", 128'(wb_trans_id_o), 128'(0));
    check("rst_exc", 128'(wb_exception_o), 128'(0));
    check("rst_ready", 128'(req_ready_o), 128'(3'b111));
    check("rst_cnt", 128'(conflict_cnt_o), 128'(0));
    check("rst_rr", 128'(dbg_rr_ptr_o), 128'(0));

    drive_req(1, 64'hAB, 3'd5);
    exc.cause = 64'd2; exc.tval = 64'h1234; exc.valid = 1'b1;
    req_exception_i[1] = exc;
    wb_ready_i = 1'b1;
    settle();
    check("single_ready_in", 128'(req_ready_o[1]), 128'(1));
    check("single_no_bypass", 128'(wb_valid_o), 128'(0));
    tick();
    req_valid_i = '0;
    settle();
    check("single_valid", 128'(wb_valid_o), 128'(1));
    check("single_grant", 128'(wb_grant_o), 128'(3'b010));
    check("single_result", 128'(wb_result_o), 128'(64'hAB));
    check("single_tid", 128'(wb_trans_id_o), 128'(5));
    check("single_exc_cause", 128'(wb_exception_o.cause), 128'(2));
    check("single_exc_tval", 128'(wb_exception_o.tval), 128'(64'h1234));
    check("single_exc_valid", 128'(wb_exception_o.valid), 128'(1));
    tick();
    check("single_drained", 128'(wb_valid_o), 128'(0));
    check("single_ready_after", 128'(req_ready_o[1]), 128'(1));
    check("single_rr", 128'(dbg_rr_ptr_o), 128'(2));

    // round robin with conflict counting
    do_reset();
    drive_req(0, 64'h10, 3'd1);
    drive_req(1, 64'h11, 3'd2);
    drive_req(2, 64'h12, 3'd3);
    wb_ready_i = 1'b1;
    tick();
    req_valid_i = '0;
    settle();
    check("rr_g0", 128'(wb_grant_o), 128'(3'b001));
    check("rr_r0", 128'(wb_result_o), 128'(64'h10));
    check("rr_c0", 128'(conflict_cnt_o), 128'(0));
    tick();
    check("rr_g1", 128'(wb_grant_o), 128'(3'b010));
    check("rr_r1", 128'(wb_trans_id_o), 128'(2));
    check("rr_c1", 128'(conflict_cnt_o), 128'(1));
    tick();
    check("rr_g2", 128'(wb_grant_o), 128'(3'b100));
    check("rr_r2", 128'(wb_result_o), 128'(64'h12));
    check("rr_c2", 128'(conflict_cnt_o), 128'(2));
    tick();
    check("rr_empty", 128'(wb_valid_o), 128'(0));
    check("rr_c_hold", 128'(conflict_cnt_o), 128'(2));

    // backpressure: req0 held while req2 fills
    do_reset();
    drive_req(0, 64'h20, 3'd4);
    tick();
    req_valid_i = '0;
    drive_req(2, 64'h22, 3'd6);
    settle();
    check("bp_ready0", 128'(req_ready_o[0]), 128'(0));
    tick();
    req_valid_i = '0;
    for (int c = 0; c < 4; c++) begin
      check("bp_grant", 128'(wb_grant_o), 128'(3'b001));
      check("bp_result", 128'(wb_result_o), 128'(64'h20));
      check("bp_tid", 128'(wb_trans_id_o), 128'(4));
      check("bp_ready0_hold", 128'(req_ready_o[0]), 128'(0));
      tick();
    end
    wb_ready_i = 1'b1;
    settle();
    check("bp_ready0_release", 128'(req_ready_o[0]), 128'(1));
    tick();
    check("bp_next_grant", 128'(wb_grant_o), 128'(3'b100));
    check("bp_next_result", 128'(wb_result_o), 128'(64'h22));
    tick();
    check("bp_drained", 128'(wb_valid_o), 128'(0));

    // no preemption: req2 presented and stalled, req0 fills below it
    wb_ready_i = 1'b0;
    drive_req(2, 64'h30, 3'd1);
    tick();
    req_valid_i = '0;
    drive_req(0, 64'h31, 3'd2);
    tick();
    req_valid_i = '0;
    settle();
    check("np_grant", 128'(wb_grant_o), 128'(3'b100));
    check("np_result", 128'(wb_result_o), 128'(64'h30));
    wb_ready_i = 1'b1;
    tick();
    check("np_after", 128'(wb_grant_o), 128'(3'b001));
    check("np_after_res", 128'(wb_result_o), 128'(64'h31));
    tick();

    // pass-through refill
    do_reset();
    drive_req(0, 64'h40, 3'd2);
    drive_req(1, 64'h41, 3'd3);
    tick();
    req_valid_i = '0;
    wb_ready_i = 1'b1;
    drive_req(0, 64'h47, 3'd7);
    settle();
    check("pt_ready", 128'(req_ready_o), 128'(3'b101));
    tick();
    req_valid_i = '0;
    settle();
    check("pt_full", 128'(dbg_state_o), 128'(3'b011));
    check("pt_rr", 128'(dbg_rr_ptr_o), 128'(1));
    check("pt_grant1", 128'(wb_grant_o), 128'(3'b010));
    check("pt_tid1", 128'(wb_trans_id_o), 128'(3));
    tick();
    check("pt_grant0", 128'(wb_grant_o), 128'(3'b001));
    check("pt_tid0", 128'(wb_trans_id_o), 128'(7));
    check("pt_res0", 128'(wb_result_o), 128'(64'h47));
    tick();

    // flush
    do_reset();
    drive_req(1, 64'h51, 3'd1);
    wb_ready_i = 1'b1;
    tick();
    req_valid_i = '0;
    tick();
    check("fl_rr_pre", 128'(dbg_rr_ptr_o), 128'(2));
    wb_ready_i = 1'b0;
    drive_req(0, 64'h60, 3'd2);
    drive_req(1, 64'h61, 3'd3);
    tick();
    req_valid_i = '0;
    flush_i = 1'b1;
    wb_ready_i = 1'b1;
    drive_req(2, 64'h62, 3'd4);
    settle();
    check("fl_ready", 128'(req_ready_o), 128'(3'b000));
    tick();
    clear_inputs();
    settle();
    check("fl_valid", 128'(wb_valid_o), 128'(0));
    check("fl_state", 128'(dbg_state_o), 128'(3'b000));
    check("fl_rr", 128'(dbg_rr_ptr_o), 128'(2));
    check("fl_cnt", 128'(conflict_cnt_o), 128'(0));
    check("fl_ready_after", 128'(req_ready_o), 128'(3'b111));

    // conflict counter saturation and async reset
    do_reset();
    drive_req(0, 64'h70, 3'd0);
    drive_req(1, 64'h71, 3'd1);
    tick();
    req_valid_i = '0;
    for (int c = 0; c < 20; c++) tick();
    check("sat_cnt", 128'(conflict_cnt_o), 128'(15));
    tick();
    check("sat_hold", 128'(conflict_cnt_o), 128'(15));
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_cnt", 128'(conflict_cnt_o), 128'(0));
    check("arst_valid", 128'(wb_valid_o), 128'(0));
    check("arst_grant", 128'(wb_grant_o), 128'(0));
    check("arst_result", 128'(wb_result_o), 128'(0));
    tick();
    rst_ni = 1'b1;
    settle();
    check("arst_ready", 128'(req_ready_o), 128'(3'b111));

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
